regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (regWrite/writeAdr/writeData, committed by the register file on negedge clk) between two sources:
  - the pipeline WB stage;
  - the multi-cycle multiply/divide unit (MDU).
- WB has absolute priority. MDU results are buffered in a small FIFO and drained into idle WB slots.
- Also reports pending-write hazards to decode and raises a stall request when MDU results are starved.

Parameters:
DEPTH, 2, MDU result FIFO entries (power of two, >=2)
MAX_WAIT, 4, consecutive cycles a non-empty FIFO may be blocked by WB before stallReq asserts

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous active-high reset
wbValid  input  1  WB stage has a register write this cycle
wbAdr  input  5  WB destination register
wbData  input  32  WB write data
mduValid  input  1  MDU offers a result
mduAdr  input  5  MDU destination register
mduData  input  32  MDU result
mduReady  output  1  arbiter can accept an MDU result this cycle
regWrite  output  1  write enable to register file
writeAdr  output  5  write address to register file
writeData  output  32  write data to register file
chkAdr1  input  5  decode source address 1
chkAdr2  input  5  decode source address 2
pending1  output  1  chkAdr1 matches a valid FIFO entry (chkAdr1 != 0)
pending2  output  1  chkAdr2 matches a valid FIFO entry (chkAdr2 != 0)
stallReq  output  1  request pipeline bubble so the FIFO can drain
fifoCount  output  $clog2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (async, rst high): FIFO count, read/write pointers and starve counter go to 0. While rst is high: regWrite=0, mduReady=0, pending1/2=0, stallReq=0, fifoCount=0. Entry contents are don't-care; valid bits are cleared.
- mduReady = !rst && (fifoCount < DEPTH). Derived from registered state only; a pop in the same cycle does not free a slot.
- MDU acceptance = mduValid && mduReady. The MDU holds mduValid/adr/data stable until accepted.
- Port select (combinational, per cycle):
  1. wbValid → write WB.
  2. else if fifoCount>0 → write FIFO head; pop at posedge.
  3. else if MDU accepted → bypass: write MDU directly, no push.
  4. else idle.
- Push: MDU accepted and not bypassed → push at posedge. A push and a pop in the same cycle leave fifoCount unchanged.
- Zero register: any selected write with address 0 drives regWrite=0 but still consumes the slot (the pop or bypass still happens). writeAdr/writeData carry the selected source regardless.
- Idle outputs: regWrite=0, writeAdr=0, writeData=0.
- FIFO ordering: strict FIFO order; pointers wrap modulo DEPTH.
- Hazard compare: pending1/2 compare against all occupied entries, combinational. The bypass value is not flagged (it is written within the same cycle).
- Starve counter:
  - Increments when fifoCount>0 && wbValid; saturates at MAX_WAIT.
  - Clears when a pop occurs or fifoCount==0.
  - stallReq = (starve==MAX_WAIT) || (fifoCount==DEPTH).
  - stallReq holds until the counter clears, or until the FIFO leaves full.
- Latency:
  - WB: 0 cycles (same-cycle write).
  - Buffered MDU result: written in the first cycle after push with wbValid=0 and all earlier entries drained.
- Reset mid-operation discards buffered results; no write is issued for them.

Test Plan:
- Reset, then wbValid=1, wbAdr=5, wbData=0x1234 → same cycle regWrite=1, writeAdr=5, writeData=0x1234; fifoCount=0.
- wbValid=0, FIFO empty, MDU adr=9 data=0xAA accepted → same-cycle bypass write to reg 9; fifoCount stays 0.
- wbValid=1 for 6 cycles while MDU pushes adr=3 then adr=4 (DEPTH=2):
  - fifoCount=2 and mduReady=0;
  - chkAdr1=3 → pending1=1;
  - stallReq=1 (full).
  - Then wbValid=0 → reg 3 written, then reg 4; count returns to 0; stallReq drops.
- One entry buffered, wbValid=1 continuously → stallReq asserts after exactly MAX_WAIT=4 blocked cycles. First wbValid=0 cycle pops; stallReq deasserts the next cycle.
- MDU result to adr=0 buffered → its drain cycle has regWrite=0 and the entry is popped; chkAdr1=0 never raises pending1.
- Two entries buffered, assert rst asynchronously mid-cycle → fifoCount=0, mduReady=0, regWrite=0 immediately. After release, no stale write occurs with wbValid=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register file's single write port between the WB
//               stage (absolute priority) and the multiply/divide unit. MDU
//               results are buffered in a small FIFO and drained into idle WB
//               slots. The block also flags pending-write hazards to decode and
//               requests a stall when buffered results are starved.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wbValid,
  input  logic [4:0]              wbAdr,
  input  logic [31:0]             wbData,
  input  logic                    mduValid,
  input  logic [4:0]              mduAdr,
  input  logic [31:0]             mduData,
  output logic                    mduReady,
  output logic                    regWrite,
  output logic [4:0]              writeAdr,
  output logic [31:0]             writeData,
  input  logic [4:0]              chkAdr1,
  input  logic [4:0]              chkAdr2,
  output logic                    pending1,
  output logic                    pending2,
  output logic                    stallReq,
  output logic [$clog2(DEPTH):0]  fifoCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] c_full     = CW'(DEPTH);
  localparam logic [SW-1:0] c_max_wait = SW'(MAX_WAIT);

  logic [CW-1:0]  count_q,  count_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [4:0]     ent_adr_q  [DEPTH];
  logic [4:0]     ent_adr_d  [DEPTH];
  logic [31:0]    ent_data_q [DEPTH];
  logic [31:0]    ent_data_d [DEPTH];

  logic           accept;
  logic           pop;
  logic           push;
  logic           bypass;
  logic           sel_valid;
  logic [4:0]     sel_adr;
  logic [31:0]    sel_data;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;

  // Write-port selection: WB first, then FIFO head, then same-cycle MDU bypass.
  always_comb begin
    mduReady  = !rst && (count_q < c_full);
    accept    = mduValid && mduReady;
    sel_valid = 1'b0;
    sel_adr   = 5'd0;
    sel_data  = 32'd0;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (wbValid) begin
      sel_valid = 1'b1;
      sel_adr   = wbAdr;
      sel_data  = wbData;
    end else if (count_q != '0) begin
      sel_valid = 1'b1;
      sel_adr   = ent_adr_q[rd_ptr_q];
      sel_data  = ent_data_q[rd_ptr_q];
      pop       = 1'b1;
    end else if (accept) begin
      sel_valid = 1'b1;
      sel_adr   = mduAdr;
      sel_data  = mduData;
      bypass    = 1'b1;
    end
    push      = accept && !bypass;
    // Writes to r0 still consume the slot but never reach the register file.
    regWrite  = !rst && sel_valid && (sel_adr != 5'd0);
    writeAdr  = sel_adr;
    writeData = sel_data;
  end

  // FIFO and starve-counter next state.
  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    valid_d    = valid_q;
    ent_adr_d  = ent_adr_q;
    ent_data_d = ent_data_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      valid_d[wr_ptr_q]    = 1'b1;
      ent_adr_d[wr_ptr_q]  = mduAdr;
      ent_data_d[wr_ptr_q] = mduData;
    end
    starve_d = starve_q;
    if (pop || (count_q == '0)) begin
      starve_d = '0;
    end else if (wbValid && (starve_q != c_max_wait)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Control state, cleared asynchronously so buffered results are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      valid_q  <= '0;
      starve_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= valid_d;
      starve_q <= starve_d;
    end
  end

  // Entry payloads need no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    ent_adr_q  <= ent_adr_d;
    ent_data_q <= ent_data_d;
  end

  // Per-entry hazard compare against decode source addresses.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_hazard
      assign hit1[i] = valid_q[i] && (ent_adr_q[i] == chkAdr1);
      assign hit2[i] = valid_q[i] && (ent_adr_q[i] == chkAdr2);
    end
  endgenerate

  assign pending1  = (chkAdr1 != 5'd0) && (|hit1);
  assign pending2  = (chkAdr2 != 5'd0) && (|hit2);
  assign stallReq  = (starve_q == c_max_wait) || (count_q == c_full);
  assign fifoCount = count_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Self-checking bench for regfile_write_arbiter: directed steps
//               followed by random traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbValid;
  logic [4:0]  wbAdr;
  logic [31:0] wbData;
  logic        mduValid;
  logic [4:0]  mduAdr;
  logic [31:0] mduData;
  logic        mduReady;
  logic        regWrite;
  logic [4:0]  writeAdr;
  logic [31:0] writeData;
  logic [4:0]  chkAdr1;
  logic [4:0]  chkAdr2;
  logic        pending1;
  logic        pending2;
  logic        stallReq;
  logic [$clog2(DEPTH):0] fifoCount;

  regfile_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .wbValid(wbValid), .wbAdr(wbAdr), .wbData(wbData),
    .mduValid(mduValid), .mduAdr(mduAdr), .mduData(mduData), .mduReady(mduReady),
    .regWrite(regWrite), .writeAdr(writeAdr), .writeData(writeData),
    .chkAdr1(chkAdr1), .chkAdr2(chkAdr2), .pending1(pending1), .pending2(pending2),
    .stallReq(stallReq), .fifoCount(fifoCount)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: pending MDU results in arrival order plus blocked-cycle count.
  logic [4:0]  q_adr  [$];
  logic [31:0] q_data [$];
  int          starve = 0;
  logic        m_accept = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Evaluate the current cycle against the model, then advance the model.
  task automatic eval(input string tag);
    logic [4:0]  ea;
    logic [31:0] ed;
    logic ew, pop, byp, rdy, p1, p2, st;
    #1;
    rdy      = (q_adr.size() < DEPTH);
    m_accept = mduValid && rdy;
    ea = 5'd0; ed = 32'd0; ew = 1'b0; pop = 1'b0; byp = 1'b0;
    if (wbValid) begin
      ea = wbAdr; ed = wbData; ew = (wbAdr != 5'd0);
    end else if (q_adr.size() > 0) begin
      ea = q_adr[0]; ed = q_data[0]; ew = (ea != 5'd0); pop = 1'b1;
    end else if (m_accept) begin
      ea = mduAdr; ed = mduData; ew = (mduAdr != 5'd0); byp = 1'b1;
    end
    p1 = 1'b0; p2 = 1'b0;
    foreach (q_adr[i]) begin
      if (chkAdr1 != 5'd0 && q_adr[i] == chkAdr1) p1 = 1'b1;
      if (chkAdr2 != 5'd0 && q_adr[i] == chkAdr2) p2 = 1'b1;
    end
    st = (starve == MAX_WAIT) || (q_adr.size() == DEPTH);
    chk({tag, ".regWrite"},  32'(regWrite),  32'(ew));
    chk({tag, ".writeAdr"},  32'(writeAdr),  32'(ea));
    chk({tag, ".writeData"}, writeData,      ed);
    chk({tag, ".mduReady"},  32'(mduReady),  32'(rdy));
    chk({tag, ".pending1"},  32'(pending1),  32'(p1));
    chk({tag, ".pending2"},  32'(pending2),  32'(p2));
    chk({tag, ".stallReq"},  32'(stallReq),  32'(st));
    chk({tag, ".fifoCount"}, 32'(fifoCount), 32'(q_adr.size()));
    if (pop || q_adr.size() == 0) starve = 0;
    else if (wbValid && starve < MAX_WAIT) starve++;
    if (pop) begin
      void'(q_adr.pop_front());
      void'(q_data.pop_front());
    end
    if (m_accept && !byp) begin
      q_adr.push_back(mduAdr);
      q_data.push_back(mduData);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wbValid = wv; wbAdr = wa; wbData = wd;
    mduValid = mv; mduAdr = ma; mduData = md;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chkAdr1 = 5'd0; chkAdr2 = 5'd0;
    #2;
    chk("reset.regWrite",  32'(regWrite),  32'd0);
    chk("reset.mduReady",  32'(mduReady),  32'd0);
    chk("reset.stallReq",  32'(stallReq),  32'd0);
    chk("reset.fifoCount", 32'(fifoCount), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // WB same-cycle write
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    eval("wb");
    chk("wb.direct", {regWrite, writeAdr, 26'd0}, {1'b1, 5'd5, 26'd0});
    tick();

    // MDU bypass into an idle slot
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hAA);
    eval("bypass");
    chk("bypass.adr", 32'(writeAdr), 32'd9);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    eval("bypass_after");
    chk("bypass.count", 32'(fifoCount), 32'd0);
    tick();

    // Fill the FIFO behind WB traffic
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33);
    eval("fill0"); tick();
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
    eval("fill1"); tick();
    chkAdr1 = 5'd3; chkAdr2 = 5'd4;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd6, 32'(i), 1'b0, 5'd0, 32'd0);
      eval("full");
      chk("full.count",    32'(fifoCount), 32'd2);
      chk("full.ready",    32'(mduReady),  32'd0);
      chk("full.pending1", 32'(pending1),  32'd1);
      chk("full.stall",    32'(stallReq),  32'd1);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    eval("drain0");
    chk("drain0.adr", 32'(writeAdr), 32'd3);
    tick();
    eval("drain1");
    chk("drain1.adr", 32'(writeAdr), 32'd4);
    tick();
    eval("drained");
    chk("drained.stall", 32'(stallReq), 32'd0);
    tick();

    // Starvation: one entry blocked by continuous WB
    chkAdr1 = 5'd0; chkAdr2 = 5'd0;
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd7, 32'h77);
    eval("starve_push"); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd8, 32'(i), 1'b0, 5'd0, 32'd0);
      eval("starve");
      chk("starve.stall", 32'(stallReq), (i == 4) ? 32'd1 : 32'd0);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    eval("starve_pop");
    chk("starve_pop.adr", 32'(writeAdr), 32'd7);
    tick();
    eval("starve_clear");
    chk("starve_clear.stall", 32'(stallReq), 32'd0);
    tick();

    // Buffered write to r0
    drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd0, 32'h55);
    eval("zero_push"); tick();
    drive(1'b1, 5'd2, 32'h3, 1'b0, 5'd0, 32'd0);
    eval("zero_hold");
    chk("zero.pending1", 32'(pending1), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    eval("zero_drain");
    chk("zero.regWrite", 32'(regWrite), 32'd0);
    chk("zero.data", writeData, 32'h55);
    tick();
    eval("zero_after");
    tick();

    // Asynchronous reset with two buffered entries
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0);
    eval("rst_fill0"); tick();
    drive(1'b1, 5'd1, 32'h2, 1'b1, 5'd11, 32'hB0);
    eval("rst_fill1"); tick();
    drive(1'b1, 5'd1, 32'h3, 1'b0, 5'd0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.fifoCount", 32'(fifoCount), 32'd0);
    chk("arst.mduReady",  32'(mduReady),  32'd0);
    chk("arst.regWrite",  32'(regWrite),  32'd0);
    chk("arst.stallReq",  32'(stallReq),  32'd0);
    q_adr.delete(); q_data.delete(); starve = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    eval("post_rst0"); tick();
    eval("post_rst1"); tick();

    // Random traffic; MDU holds its offer until accepted
    m_accept = 1'b0;
    for (int n = 0; n < 400; n++) begin
      wbValid = ($urandom_range(0, 99) < 60);
      wbAdr   = 5'($urandom_range(0, 31));
      wbData  = $urandom;
      if (!(mduValid && !m_accept)) begin
        mduValid = ($urandom_range(0, 99) < 50);
        mduAdr   = 5'($urandom_range(0, 7));
        mduData  = $urandom;
      end
      chkAdr1 = 5'($urandom_range(0, 7));
      chkAdr2 = 5'($urandom_range(0, 7));
      eval("rand");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
